// File: rtl/parallel_to_serial_pkg.sv
// parallel_to_serial_pkg: shared state encoding and byte width for the serializer
package parallel_to_serial_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: captures an N-bit word on an rx_valid rising edge and emits it LSB byte first
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int N = 32,
  parameter int Ndiv4log2 = 3
) (
  input  logic          iCE_CLK,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [N-1:0]  rx_bytes,
  input  logic          is_transmitting,
  output logic [7:0]    tx_byte,
  output logic          tx_valid
);
  localparam int SW = $clog2(N);
  localparam logic [Ndiv4log2-1:0] LAST = Ndiv4log2'(N / BYTE_W - 1);
  state_t state;
  logic [N-1:0] word;
  logic [Ndiv4log2-1:0] idx, nxt;
  logic [SW-1:0] sel;
  logic rx_prev;
  assign nxt = idx + 1'b1;
  assign sel = SW'(int'(nxt) * BYTE_W);
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      word     <= '0;
      tx_byte  <= '0;
      tx_valid <= 1'b0;
      rx_prev  <= 1'b0;
    end else begin
      rx_prev <= rx_valid;
      if (state == IDLE) begin
        tx_valid <= rx_valid && !rx_prev;
        if (rx_valid && !rx_prev) begin
          word    <= rx_bytes;
          idx     <= '0;
          tx_byte <= rx_bytes[BYTE_W-1:0];
          state   <= SEND;
        end
      end else if (is_transmitting) begin
        tx_valid <= 1'b0;
      end else if (idx != LAST) begin
        idx      <= nxt;
        tx_byte  <= word[sel +: BYTE_W];
        tx_valid <= 1'b1;
      end else begin
        tx_valid <= 1'b0;
        state    <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: directed checks of the serializer at N=32 and N=64
module tb_parallel_to_serial;
  logic clk = 1'b0;
  logic rst_n, rx_valid, rx_valid2, is_tx;
  logic [31:0] rx_bytes;
  logic [63:0] rx_bytes2;
  logic [7:0] tx_byte, tx_byte2;
  logic tx_valid, tx_valid2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  parallel_to_serial #(.N(32), .Ndiv4log2(3)) dut (
    .iCE_CLK(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bytes(rx_bytes),
    .is_transmitting(is_tx), .tx_byte(tx_byte), .tx_valid(tx_valid)
  );

  parallel_to_serial #(.N(64), .Ndiv4log2(3)) dut64 (
    .iCE_CLK(clk), .rst_n(rst_n), .rx_valid(rx_valid2), .rx_bytes(rx_bytes2),
    .is_transmitting(is_tx), .tx_byte(tx_byte2), .tx_valid(tx_valid2)
  );

  task automatic chk(input string tag, input logic [7:0] b, input logic v,
                     input logic [7:0] eb, input logic ev);
    total++;
    assert ({b, v} === {eb, ev})
    else begin
      bad++;
      $error("FAIL %s: got byte=%h valid=%b, want byte=%h valid=%b", tag, b, v, eb, ev);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] eb, input logic ev);
    @(posedge clk);
    #1;
    chk(tag, tx_byte, tx_valid, eb, ev);
  endtask

  task automatic step64(input string tag, input logic [7:0] eb, input logic ev);
    @(posedge clk);
    #1;
    chk(tag, tx_byte2, tx_valid2, eb, ev);
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_valid2 = 1'b0; is_tx = 1'b0;
    rx_bytes = '0; rx_bytes2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset32", tx_byte, tx_valid, 8'h00, 1'b0);
    chk("reset64", tx_byte2, tx_valid2, 8'h00, 1'b0);
    rst_n = 1'b1;
    // basic sequence with rx_valid held high
    rx_valid = 1'b1; rx_bytes = 32'hDDCCBBAA;
    step("basic_aa", 8'hAA, 1'b1);
    step("basic_bb", 8'hBB, 1'b1);
    step("basic_cc", 8'hCC, 1'b1);
    step("basic_dd", 8'hDD, 1'b1);
    step("basic_end", 8'hDD, 1'b0);
    // held rx_valid must not retrigger
    step("held_1", 8'hDD, 1'b0);
    step("held_2", 8'hDD, 1'b0);
    rx_valid = 1'b0;
    step("rearm_low", 8'hDD, 1'b0);
    rx_valid = 1'b1; rx_bytes = 32'h44332211;
    step("rearm_11", 8'h11, 1'b1);
    step("rearm_22", 8'h22, 1'b1);
    step("rearm_33", 8'h33, 1'b1);
    step("rearm_44", 8'h44, 1'b1);
    step("rearm_end", 8'h44, 1'b0);
    // backpressure after the first byte
    rx_valid = 1'b0;
    step("bp_low", 8'h44, 1'b0);
    rx_valid = 1'b1; rx_bytes = 32'hDDCCBBAA;
    step("bp_aa", 8'hAA, 1'b1);
    is_tx = 1'b1;
    step("bp_hold1", 8'hAA, 1'b0);
    step("bp_hold2", 8'hAA, 1'b0);
    is_tx = 1'b0;
    step("bp_bb", 8'hBB, 1'b1);
    step("bp_cc", 8'hCC, 1'b1);
    step("bp_dd", 8'hDD, 1'b1);
    step("bp_end", 8'hDD, 1'b0);
    // input changes during SEND are ignored
    rx_valid = 1'b0;
    step("chg_low", 8'hDD, 1'b0);
    rx_valid = 1'b1; rx_bytes = 32'hDDCCBBAA;
    step("chg_aa", 8'hAA, 1'b1);
    rx_valid = 1'b0; rx_bytes = 32'h12345678;
    step("chg_bb", 8'hBB, 1'b1);
    rx_valid = 1'b1;
    step("chg_cc", 8'hCC, 1'b1);
    step("chg_dd", 8'hDD, 1'b1);
    step("chg_end", 8'hDD, 1'b0);
    step("chg_idle", 8'hDD, 1'b0);
    // capture allowed while downstream busy in IDLE, then async reset mid-word
    rx_valid = 1'b0; is_tx = 1'b1;
    step("busy_idle", 8'hDD, 1'b0);
    rx_valid = 1'b1; rx_bytes = 32'hDDCCBBAA;
    step("busy_cap_aa", 8'hAA, 1'b1);
    step("busy_hold", 8'hAA, 1'b0);
    is_tx = 1'b0;
    step("rst_bb", 8'hBB, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", tx_byte, tx_valid, 8'h00, 1'b0);
    rx_valid = 1'b0;
    step("rst_held", 8'h00, 1'b0);
    rst_n = 1'b1;
    step("rst_no_cc", 8'h00, 1'b0);
    step("rst_no_dd", 8'h00, 1'b0);
    // first clock after reset release captures a high rx_valid
    rst_n = 1'b0; rx_valid = 1'b1; rx_bytes = 32'hDDCCBBAA;
    #1;
    rst_n = 1'b1;
    step("post_rst_aa", 8'hAA, 1'b1);
    step("post_rst_bb", 8'hBB, 1'b1);
    step("post_rst_cc", 8'hCC, 1'b1);
    step("post_rst_dd", 8'hDD, 1'b1);
    step("post_rst_end", 8'hDD, 1'b0);
    // 64-bit instance
    rx_valid2 = 1'b1; rx_bytes2 = 64'h8877665544332211;
    step64("w64_11", 8'h11, 1'b1);
    step64("w64_22", 8'h22, 1'b1);
    step64("w64_33", 8'h33, 1'b1);
    step64("w64_44", 8'h44, 1'b1);
    step64("w64_55", 8'h55, 1'b1);
    step64("w64_66", 8'h66, 1'b1);
    step64("w64_77", 8'h77, 1'b1);
    step64("w64_88", 8'h88, 1'b1);
    step64("w64_end", 8'h88, 1'b0);
    step64("w64_held", 8'h88, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter N, default 32: width of the parallel input word in bits; N SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter Ndiv4log2, default 3: width of the internal byte-index counter; the design SHALL require 2^Ndiv4log2 >= N/8.
REQ-003 iCE_CLK  input  1: single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 rx_valid  input  1: parallel word available on rx_bytes.
REQ-006 rx_bytes  input  N: parallel word; byte 0 is rx_bytes[7:0].
REQ-007 is_transmitting  input  1: downstream serializer (UART TX) is busy.
REQ-008 tx_byte  output  8: byte currently offered downstream.
REQ-009 tx_valid  output  1: tx_byte is a new byte to transmit this cycle.

Function
REQ-010 The design SHALL have two states: IDLE and SEND.
REQ-011 A capture SHALL occur in IDLE on a rising edge where rx_valid=1 and the registered previous rx_valid=0.
REQ-012 On capture, the design SHALL register rx_bytes and set index=0.
- tx_byte <= rx_bytes[7:0], tx_valid <= 1, state <= SEND.
- Latency from rx_valid sampled high to tx_valid high is 1 clock.
REQ-013 In SEND with is_transmitting=1, the design SHALL hold index and tx_byte and drive tx_valid <= 0.
REQ-014 In SEND with is_transmitting=0 and index < N/8-1, the design SHALL increment index.
- tx_byte <= byte[index+1], tx_valid <= 1.
- Consecutive bytes may therefore issue on consecutive cycles.
REQ-015 In SEND with is_transmitting=0 and index = N/8-1, the design SHALL drive tx_valid <= 0 and state <= IDLE.
- tx_byte keeps the last byte.
REQ-016 Bytes SHALL be emitted least-significant first: byte k = word[8k+7:8k].
REQ-017 rx_valid and rx_bytes SHALL be ignored while in SEND; the captured word SHALL NOT change mid-sequence.
REQ-018 Rearm rule: holding rx_valid high SHALL NOT retrigger a capture; a new capture requires rx_valid to be sampled low, then high, while in IDLE.
REQ-019 If is_transmitting=1 while in IDLE, the design SHALL stay in IDLE; capture is still permitted per REQ-011.
REQ-020 tx_valid SHALL be a registered output with no combinational path from any input.

Reset
REQ-021 While rst_n=0, the design SHALL force state=IDLE, index=0, tx_byte=8'h00, tx_valid=0, the stored word to 0 and previous rx_valid to 0, asynchronously.
REQ-022 Reset asserted mid-sequence SHALL abort the word with no further tx_valid.
REQ-023 After reset release, a capture SHALL occur on the first clock where rx_valid=1.

Structure
REQ-024 The state encoding (IDLE, SEND) and the byte width constant 8 SHALL live in a shared package.
REQ-025 The design SHALL be a single module with no sub-modules; the byte mux is an indexed part-select.

Verification
REQ-026 Basic sequence: N=32, rx_valid=1 (held), rx_bytes=32'hDDCCBBAA, is_transmitting=0 -> tx_byte/tx_valid on successive cycles = AA/1, BB/1, CC/1, DD/1, then tx_valid=0.
REQ-027 Backpressure: same word, is_transmitting=1 for the cycle after AA -> that cycle gives AA/0; after release -> BB/1, CC/1, DD/1, then tx_valid=0.
REQ-028 Rearm: rx_valid held high after DD -> no further tx_valid; rx_valid low one cycle then high with 32'h44332211 -> 11, 22, 33, 44.
REQ-029 Input change while busy: rx_bytes changed to 32'h12345678 during SEND -> remaining bytes still come from 32'hDDCCBBAA.
REQ-030 Reset mid-sequence: rst_n=0 after BB -> tx_valid=0 and tx_byte=00 immediately (asynchronously); no CC/DD after release until a new capture.
REQ-031 Parameter check: N=64, Ndiv4log2=3, word 64'h8877665544332211 -> bytes 11 through 88 in order, then tx_valid=0.
